// File: rtl/bus_resp_pkg.sv
// bus_resp_pkg: shared types and constants for the conv-bus memory responder.
//   state_t : responder FSM states
//   ID_W    : transaction id width
//   LEN_W   : burst length field width (beats minus 1)
package bus_resp_pkg;
  localparam int ID_W  = 4;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LAT  = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;
endpackage

// File: rtl/bus_mem_responder_if.sv
// bus_mem_responder_if: conv-bus signals between an initiator and the memory
// responder.
//   master : initiator view (drives addr, ar*/aw*, wdata, wstrb)
//   slave  : responder view (drives arready, awready, r*, wready, wuser_*)
interface bus_mem_responder_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 28
);
  import bus_resp_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic               arvalid;
  logic               arready;
  logic [ID_W-1:0]    aruser_id;
  logic [LEN_W-1:0]   arlen;
  logic               aruser_ap;
  logic               rvalid;
  logic [WIDTH-1:0]   rdata;
  logic [ID_W-1:0]    rid;
  logic               rlast;
  logic               awvalid;
  logic               awready;
  logic [ID_W-1:0]    awuser_id;
  logic [LEN_W-1:0]   awlen;
  logic               awuser_ap;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH/8-1:0] wstrb;
  logic               wready;
  logic [ID_W-1:0]    wuser_id;
  logic               wuser_last;

  modport master (
    output addr, arvalid, aruser_id, arlen, aruser_ap,
           awvalid, awuser_id, awlen, awuser_ap, wdata, wstrb,
    input  arready, rvalid, rdata, rid, rlast, awready, wready, wuser_id, wuser_last
  );

  modport slave (
    input  addr, arvalid, aruser_id, arlen, aruser_ap,
           awvalid, awuser_id, awlen, awuser_ap, wdata, wstrb,
    output arready, rvalid, rdata, rid, rlast, awready, wready, wuser_id, wuser_last
  );
endinterface

// File: rtl/bus_resp_sram.sv
// bus_resp_sram: single-port synchronous RAM, byte write enables, 1-cycle
// registered read. A write and read to the same address in one cycle returns
// the old word.
//   clk   : clock
//   addr  : word address
//   we    : per-byte write enable
//   wdata : write data
//   q     : read data, valid the cycle after addr is presented
module bus_resp_sram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH/8-1:0]    we,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      q
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH/8; i++)
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side target for the conv bus. Serves one read
// (ar/r) or write (aw/w) burst at a time from an internal word SRAM.
//   clk, rst_n : clock, async active-low reset
//   bus        : conv-bus slave modport (ar/r read channel, aw/w write channel)
// Build option: BUS_RESP_RR_ARB_EN selects round-robin read/write arbitration
// in IDLE; otherwise reads always win a simultaneous request.
module bus_mem_responder
  import bus_resp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 28,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_mem_responder_if.slave    bus
);
  localparam int CNT_W = LEN_W + 1;

  state_t                state, nxt;
  logic [DEPTH_LOG2-1:0] base;
  logic [ID_W-1:0]       id_q;
  logic [LEN_W-1:0]      len_q;
  logic                  ap_q;
  // Read: index of the array read being issued (one ahead of the beat on the
  // bus). Write: index of the current beat.
  logic [CNT_W-1:0]      cnt;
  logic                  idle, ar_go, aw_go, rd_last, wr_last;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2];

  // Ready is gated by rst_n so it drops the moment reset asserts.
  assign idle = rst_n && (state == IDLE);

`ifdef BUS_RESP_RR_ARB_EN
  // prio_wr=1: the write side gets a simultaneous request.
  logic prio_wr;
  assign bus.arready = idle && !(bus.awvalid && prio_wr);
  assign bus.awready = idle && !(bus.arvalid && !prio_wr);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     prio_wr <= 1'b0;
    else if (ar_go) prio_wr <= 1'b1;
    else if (aw_go) prio_wr <= 1'b0;
`else
  assign bus.arready = idle;
  assign bus.awready = idle && !bus.arvalid;
`endif

  assign ar_go = bus.arvalid && bus.arready;
  assign aw_go = bus.awvalid && bus.awready;

  assign rd_last = (state == RD_DATA) && (cnt == CNT_W'(len_q) + CNT_W'(1));
  assign wr_last = (state == WR_DATA) && (cnt == CNT_W'(len_q));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (ar_go) nxt = RD_LAT;
               else if (aw_go) nxt = WR_DATA;
      RD_LAT:  nxt = RD_DATA;
      RD_DATA: if (rd_last) nxt = IDLE;
      WR_DATA: if (wr_last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base  <= '0;
      id_q  <= '0;
      len_q <= '0;
      ap_q  <= 1'b0;
      cnt   <= '0;
    end else if (ar_go) begin
      base  <= bus.addr[DEPTH_LOG2-1:0];
      id_q  <= bus.aruser_id;
      len_q <= bus.arlen;
      ap_q  <= bus.aruser_ap;
      cnt   <= '0;
    end else if (aw_go) begin
      base  <= bus.addr[DEPTH_LOG2-1:0];
      id_q  <= bus.awuser_id;
      len_q <= bus.awlen;
      ap_q  <= bus.awuser_ap;
      cnt   <= '0;
    end else if (state != IDLE) begin
      cnt   <= cnt + CNT_W'(1);
    end

  // Wraps naturally at the top of the array. The extra read issued during the
  // last beat is never consumed.
  assign mem_addr = ap_q ? base + DEPTH_LOG2'(cnt) : base;

  bus_resp_sram #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (bus.wready ? bus.wstrb : '0),
    .wdata (bus.wdata),
    .q     (mem_q)
  );

  assign bus.rvalid     = rst_n && (state == RD_DATA);
  assign bus.rdata      = bus.rvalid ? mem_q : '0;
  assign bus.rid        = id_q;
  assign bus.rlast      = rst_n && rd_last;
  assign bus.wready     = rst_n && (state == WR_DATA);
  assign bus.wuser_id   = id_q;
  assign bus.wuser_last = rst_n && wr_last;
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed self-checking bench for bus_mem_responder.
module tb_bus_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] wd_q [16];
  logic [31:0] ex_q [16];

  always #5 clk = ~clk;

  bus_mem_responder_if #(.WIDTH(32), .ADDR_W(28)) bus();

  bus_mem_responder #(.WIDTH(32), .ADDR_W(28), .DEPTH_LOG2(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_burst(input logic [27:0] a, input logic [3:0] len, input logic ap,
                          input logic [3:0] id, input logic [3:0] strb);
    bus.addr = a; bus.awlen = len; bus.awuser_ap = ap; bus.awuser_id = id;
    bus.awvalid = 1'b1;
    #1 chk("awready", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bus.wdata = wd_q[k]; bus.wstrb = strb;
      #1;
      chk("wready", 32'(bus.wready), 32'd1);
      chk("wuser_id", 32'(bus.wuser_id), 32'(id));
      chk("wuser_last", 32'(bus.wuser_last), 32'(k == int'(len)));
      tick();
    end
    bus.wstrb = '0;
    chk("wready_end", 32'(bus.wready), 32'd0);
  endtask

  task automatic rd_burst(input logic [27:0] a, input logic [3:0] len, input logic ap,
                          input logic [3:0] id);
    bus.addr = a; bus.arlen = len; bus.aruser_ap = ap; bus.aruser_id = id;
    bus.arvalid = 1'b1;
    #1 chk("arready", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_lat", 32'(bus.rvalid), 32'd0);
    tick();
    for (int k = 0; k <= int'(len); k++) begin
      chk("rvalid", 32'(bus.rvalid), 32'd1);
      chk("rdata", bus.rdata, ex_q[k]);
      chk("rid", 32'(bus.rid), 32'(id));
      chk("rlast", 32'(bus.rlast), 32'(k == int'(len)));
      tick();
    end
    chk("rvalid_end", 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    bus.addr = '0; bus.arvalid = 0; bus.aruser_id = 0; bus.arlen = 0; bus.aruser_ap = 0;
    bus.awvalid = 0; bus.awuser_id = 0; bus.awlen = 0; bus.awuser_ap = 0;
    bus.wdata = '0; bus.wstrb = '0;

    // reset state
    #2;
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("idle_arready", 32'(bus.arready), 32'd1);
    chk("idle_awready", 32'(bus.awready), 32'd1);
    tick();

    // incrementing write then read-back
    for (int k = 0; k < 4; k++) wd_q[k] = 32'hA0A0_0000 | k;
    wr_burst(28'h010, 4'd3, 1'b1, 4'd5, 4'hF);
    ex_q[0] = 32'hA0A0_0000; ex_q[1] = 32'hA0A0_0001;
    ex_q[2] = 32'hA0A0_0002; ex_q[3] = 32'hA0A0_0003;
    rd_burst(28'h010, 4'd3, 1'b1, 4'd9);

    // upper address bits ignored
    rd_burst(28'hABC_D010, 4'd3, 1'b1, 4'd2);

    // byte strobes
    wd_q[0] = 32'h1122_3344;
    wr_burst(28'h030, 4'd0, 1'b1, 4'd1, 4'hF);
    wd_q[0] = 32'hDEAD_BEEF;
    wr_burst(28'h030, 4'd0, 1'b1, 4'd1, 4'h5);
    ex_q[0] = 32'h11AD_33EF;
    rd_burst(28'h030, 4'd0, 1'b1, 4'd1);

    // wrap at top of array, both directions
    wd_q[0] = 32'hB000_0FFE; wd_q[1] = 32'hB000_0FFF;
    wd_q[2] = 32'hB000_0000; wd_q[3] = 32'hB000_0001;
    wr_burst(28'hFFE, 4'd3, 1'b1, 4'd6, 4'hF);
    ex_q[0] = 32'hB000_0FFE; ex_q[1] = 32'hB000_0FFF;
    ex_q[2] = 32'hB000_0000; ex_q[3] = 32'hB000_0001;
    rd_burst(28'hFFE, 4'd3, 1'b1, 4'd7);
    ex_q[0] = 32'hB000_0FFE; ex_q[1] = 32'hB000_0FFE;
    ex_q[2] = 32'hB000_0FFE; ex_q[3] = 32'hB000_0FFE;
    rd_burst(28'hFFE, 4'd3, 1'b0, 4'd7);

    // 16-beat burst
    for (int k = 0; k < 16; k++) wd_q[k] = 32'hC000_0100 + k;
    wr_burst(28'h100, 4'd15, 1'b1, 4'd3, 4'hF);
    for (int k = 0; k < 16; k++) ex_q[k] = 32'hC000_0100 + k;
    rd_burst(28'h100, 4'd15, 1'b1, 4'd4);

    // read in the cycle right after a single-beat write's last beat
    wd_q[0] = 32'h0BAD_F00D;
    wr_burst(28'h020, 4'd0, 1'b1, 4'd8, 4'hF);
    ex_q[0] = 32'h0BAD_F00D;
    rd_burst(28'h020, 4'd0, 1'b1, 4'd8);

    // simultaneous request: read wins, write waits for IDLE
    bus.addr = 28'h010; bus.arlen = 0; bus.aruser_ap = 1; bus.aruser_id = 4'd3;
    bus.awlen = 0; bus.awuser_ap = 1; bus.awuser_id = 4'd4;
    bus.arvalid = 1; bus.awvalid = 1;
    #1;
    chk("col_arready", 32'(bus.arready), 32'd1);
    chk("col_awready", 32'(bus.awready), 32'd0);
    tick();
    bus.arvalid = 0; bus.addr = 28'h040;
    chk("col_awready_lat", 32'(bus.awready), 32'd0);
    tick();
    chk("col_rvalid", 32'(bus.rvalid), 32'd1);
    chk("col_rdata", bus.rdata, 32'hA0A0_0000);
    chk("col_rlast", 32'(bus.rlast), 32'd1);
    chk("col_awready_rd", 32'(bus.awready), 32'd0);
    tick();
    chk("col_awready_idle", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 0; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
    #1;
    chk("col_wready", 32'(bus.wready), 32'd1);
    chk("col_wuser_id", 32'(bus.wuser_id), 32'd4);
    chk("col_wlast", 32'(bus.wuser_last), 32'd1);
    tick();
    bus.wstrb = 0;
    ex_q[0] = 32'h5555_AAAA;
    rd_burst(28'h040, 4'd0, 1'b1, 4'd4);

    // reset during the second beat of an 8-beat read
    bus.addr = 28'h100; bus.arlen = 4'd7; bus.aruser_ap = 1; bus.aruser_id = 4'd2;
    bus.arvalid = 1;
    tick();
    bus.arvalid = 0;
    tick();
    chk("rst_mid_beat0", 32'(bus.rvalid), 32'd1);
    tick();
    chk("rst_mid_beat1", bus.rdata, 32'hC000_0101);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_mid_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_mid_arready", 32'(bus.arready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_arready", 32'(bus.arready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_no_stale", 32'(bus.rvalid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
